// File: rtl/fft_out_buf_pkg.sv
// Shared widths, sizes and drain-FSM state type
// for the FFT output reorder buffer.
package fft_out_buf_pkg;
  localparam int FFT_IDX_WD     = 6;
  localparam int FFT_GRP_IDX_WD = 3;
  localparam int SIZE_FFT       = 64;
  localparam int SIZE_GRP       = 8;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } drn_st_e;
endpackage

// File: rtl/fft_pp_bank.sv
// One 64-entry ping-pong bank: 8-wide group write,
// single combinational read port. Contents are not reset.
module fft_pp_bank
  import fft_out_buf_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [FFT_GRP_IDX_WD-1:0] grp_i,
  input  logic [SIZE_GRP*W-1:0]     dat_i,
  input  logic [FFT_IDX_WD-1:0]     addr_i,
  output logic [W-1:0]              dat_o
);
  logic [W-1:0] mem_q [SIZE_FFT];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < SIZE_GRP; k++) begin
        mem_q[{grp_i, 3'(k)}] <= dat_i[k*W +: W];
      end
    end
  end

  assign dat_o = mem_q[addr_i];
endmodule

// File: rtl/fft_out_buf.sv
// FFT output stage: collects 8-point groups into ping-pong
// banks and drains each full frame in natural order.
module fft_out_buf
  import fft_out_buf_pkg::*;
#(
  parameter int DATA_RE_WD = 16,
  parameter int DATA_IM_WD = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_val_i,
  input  logic [FFT_GRP_IDX_WD-1:0]                wr_grp_i,
  input  logic [SIZE_GRP*(DATA_RE_WD+DATA_IM_WD)-1:0] wr_dat_i,
  output logic                                     wr_rdy_o,
  output logic                                     val_o,
  output logic [DATA_RE_WD-1:0]                    fft_dat_re_o,
  output logic [DATA_IM_WD-1:0]                    fft_dat_im_o,
  output logic [FFT_IDX_WD-1:0]                    idx_o,
  output logic                                     last_o,
  output logic                                     err_o
);
  localparam int PW = DATA_RE_WD + DATA_IM_WD;

  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [1:0]            full_q, full_d;
  logic [SIZE_GRP-1:0]   mask_q, mask_d;
  drn_st_e               st_q, st_d;
  logic [FFT_IDX_WD-1:0] cnt_q, cnt_d;
  logic                  val_q, val_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [PW-1:0]         pt_q, pt_d;

  logic                  wr_acc;
  logic [SIZE_GRP-1:0]   grp_bit;
  logic [SIZE_GRP-1:0]   mask_set;
  logic                  drn_end;
  logic                  rd_bank;
  logic [FFT_IDX_WD-1:0] rd_addr;
  logic [PW-1:0]         rd_dat0, rd_dat1, rd_pt;

  assign wr_rdy_o = !full_q[wbank_q];
  assign wr_acc   = wr_val_i && wr_rdy_o;
  assign grp_bit  = SIZE_GRP'(1) << wr_grp_i;
  assign mask_set = mask_q | grp_bit;
  assign drn_end  = (st_q == ST_DRAIN) && (&cnt_q);

  // Read one point ahead; at drain end peek at the other bank's point 0
  assign rd_bank = drn_end ? ~rbank_q : rbank_q;
  assign rd_addr = (st_q == ST_DRAIN) ? cnt_q + 6'd1 : '0;
  assign rd_pt   = rd_bank ? rd_dat1 : rd_dat0;

  fft_pp_bank #(.W(PW)) u_bank0 (
    .clk    (clk),
    .we_i   (wr_acc && !wbank_q),
    .grp_i  (wr_grp_i),
    .dat_i  (wr_dat_i),
    .addr_i (rd_addr),
    .dat_o  (rd_dat0)
  );

  fft_pp_bank #(.W(PW)) u_bank1 (
    .clk    (clk),
    .we_i   (wr_acc && wbank_q),
    .grp_i  (wr_grp_i),
    .dat_i  (wr_dat_i),
    .addr_i (rd_addr),
    .dat_o  (rd_dat1)
  );

  always_comb begin
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    mask_d  = mask_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    val_d   = 1'b0;
    last_d  = 1'b0;
    pt_d    = '0;
    err_d   = wr_acc && |(mask_q & grp_bit);

    if (wr_acc) begin
      mask_d = mask_set;
      if (&mask_set) begin
        full_d[wbank_q] = 1'b1;
        mask_d          = '0;
        wbank_d         = ~wbank_q;
      end
    end

    unique case (st_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          st_d  = ST_DRAIN;
          cnt_d = '0;
          val_d = 1'b1;
          pt_d  = rd_pt;
        end
      end
      ST_DRAIN: begin
        if (drn_end) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          cnt_d           = '0;
          if (full_q[~rbank_q]) begin
            val_d = 1'b1;
            pt_d  = rd_pt;
          end else begin
            st_d = ST_IDLE;
          end
        end else begin
          cnt_d  = cnt_q + 6'd1;
          val_d  = 1'b1;
          pt_d   = rd_pt;
          last_d = (cnt_q == 6'd62);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      mask_q  <= '0;
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      pt_q    <= '0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      mask_q  <= mask_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      last_q  <= last_d;
      err_q   <= err_d;
      pt_q    <= pt_d;
    end
  end

  assign val_o        = val_q;
  assign idx_o        = cnt_q;
  assign last_o       = last_q;
  assign err_o        = err_q;
  assign fft_dat_re_o = pt_q[PW-1 -: DATA_RE_WD];
  assign fft_dat_im_o = pt_q[DATA_IM_WD-1:0];
endmodule

// File: tb/tb_fft_out_buf.sv
// Randomized bench for fft_out_buf against a frame-queue
// reference model.
module tb_fft_out_buf;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_val_i = 1'b0;
  logic [2:0]   wr_grp_i = '0;
  logic [255:0] wr_dat_i = '0;
  logic         wr_rdy_o;
  logic         val_o;
  logic [15:0]  fft_dat_re_o;
  logic [15:0]  fft_dat_im_o;
  logic [5:0]   idx_o;
  logic         last_o;
  logic         err_o;

  fft_out_buf dut (
    .clk          (clk),
    .rst          (rst),
    .wr_val_i     (wr_val_i),
    .wr_grp_i     (wr_grp_i),
    .wr_dat_i     (wr_dat_i),
    .wr_rdy_o     (wr_rdy_o),
    .val_o        (val_o),
    .fft_dat_re_o (fft_dat_re_o),
    .fft_dat_im_o (fft_dat_im_o),
    .idx_o        (idx_o),
    .last_o       (last_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Full frames awaiting/under drain, 64 points each, oldest first
  logic [31:0] pts[$];
  logic [31:0] cur[64];
  logic [31:0] src[64];
  logic [7:0]  mask = '0;
  bit          e_val = 0;
  bit          e_err = 0;
  int          e_idx = 0;
  int          ord[8];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pts.delete();
    mask  = '0;
    e_val = 0;
    e_idx = 0;
    e_err = 0;
  endtask

  task automatic model_step();
    bit rdy_pre;
    bit acc;
    if (!rst) begin
      model_reset();
      return;
    end
    rdy_pre = pts.size() < 128;
    if (e_val && e_idx == 63) begin
      repeat (64) void'(pts.pop_front());
      e_val = pts.size() > 0;
      e_idx = 0;
    end else if (e_val) begin
      e_idx++;
    end else if (pts.size() > 0) begin
      e_val = 1;
      e_idx = 0;
    end
    acc   = wr_val_i && rdy_pre;
    e_err = acc && mask[wr_grp_i];
    if (acc) begin
      for (int k = 0; k < 8; k++)
        cur[8*wr_grp_i+k] = wr_dat_i[32*k +: 32];
      mask[wr_grp_i] = 1'b1;
      if (mask == 8'hFF) begin
        for (int n = 0; n < 64; n++) pts.push_back(cur[n]);
        mask = '0;
      end
    end
  endtask

  task automatic check_out();
    logic [31:0] ep;
    ep = '0;
    if (e_val && pts.size() > e_idx) ep = pts[e_idx];
    chk("val", 32'(val_o), 32'(e_val));
    chk("idx", 32'(idx_o), 32'(e_val ? e_idx : 0));
    chk("re", 32'(fft_dat_re_o), 32'(ep[31:16]));
    chk("im", 32'(fft_dat_im_o), 32'(ep[15:0]));
    chk("last", 32'(last_o), 32'(e_val && e_idx == 63));
    chk("err", 32'(err_o), 32'(e_err));
    chk("rdy", 32'(wr_rdy_o), 32'(pts.size() < 128));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_out();
  endtask

  task automatic put(input int g);
    int t;
    t = 0;
    wr_val_i = 1'b1;
    wr_grp_i = 3'(g);
    for (int k = 0; k < 8; k++)
      wr_dat_i[32*k +: 32] = src[8*g+k];
    while (pts.size() >= 128 && t < 400) begin
      step();
      t++;
    end
    chk("wr_tmo", 32'(t < 400), 32'd1);
    step();
    wr_val_i = 1'b0;
  endtask

  task automatic fill(input bit rnd);
    for (int n = 0; n < 64; n++) begin
      if (rnd) src[n] = $urandom;
      else src[n] = {16'(n), 16'(-n)};
    end
  endtask

  task automatic frame_in_order();
    for (int g = 0; g < 8; g++) put(g);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((pts.size() > 0 || e_val) && t < 1000) begin
      step();
      t++;
    end
    chk("drain_tmo", 32'(t < 1000), 32'd1);
    repeat (2) step();
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check_out();
    rst = 1'b1;
    step();

    fill(0);
    frame_in_order();
    drain();

    ord = '{7, 3, 0, 5, 1, 6, 2, 4};
    fill(0);
    for (int i = 0; i < 8; i++) put(ord[i]);
    drain();

    fill(1);
    frame_in_order();
    fill(1);
    frame_in_order();
    drain();

    repeat (3) begin
      fill(1);
      frame_in_order();
    end
    drain();

    fill(1);
    put(0);
    put(1);
    put(2);
    for (int n = 16; n < 24; n++) src[n] = 32'h0055_0055;
    put(2);
    for (int g = 3; g < 8; g++) put(g);
    drain();

    fill(1);
    frame_in_order();
    fill(1);
    for (int g = 0; g < 4; g++) put(g);
    t = 0;
    while (!(e_val && e_idx == 30) && t < 200) begin
      step();
      t++;
    end
    chk("idx30_tmo", 32'(t < 200), 32'd1);
    #1 rst = 1'b0;
    #1 model_reset();
    check_out();
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    fill(0);
    frame_in_order();
    drain();

    for (int c = 0; c < 2500; c++) begin
      wr_val_i = ($urandom_range(0, 3) != 0);
      wr_grp_i = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) wr_dat_i[32*k +: 32] = $urandom;
      step();
    end
    wr_val_i = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
